spi_req_arbiter: RTL and testbench
==================================

# spi_req_arbiter

Round-robin arbiter and transaction sequencer that shares the single `spi` flash-style master between two requesters. It latches one requester's command, address and write data, drives the `spi` core's `enable/commands/address/data_out` inputs for exactly one frame, and ends the frame by counting `SCLK` rising edges returned from the core. A per-frame watchdog aborts a frame that stalls.

## Interface
- `FRAME_BITS`, 64: `SCLK` rising edges per frame (8 command + 24 address + 32 data).
- `TIMEOUT`, 1023: maximum `clk` cycles between `SCLK` rising edges before the frame is aborted.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request; held high until the matching `gnt`.
- `cmd0`, `cmd1`  in  8  command byte.
- `addr0`, `addr1`  in  24  flash address.
- `wdata0`, `wdata1`  in  32  write data.
- `gnt0`, `gnt1`  out  1  one-cycle pulse; request inputs are latched on this cycle.
- `done0`, `done1`  out  1  one-cycle pulse at frame end, or at abort.
- `sclk`  in  1  `SCLK` fed back from the `spi` core.
- `enable`  out  1  to `spi.enable`.
- `commands`  out  8  to `spi.commands`.
- `address`  out  24  to `spi.address`.
- `data_out`  out  32  to `spi.data_out`.
- `busy`  out  1  high in RUN and DONE.
- `err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- **States:**
  - IDLE: if `req0|req1`, select a winner and go to RUN. Otherwise stay.
  - RUN: count `SCLK` edges. On edge count == `FRAME_BITS`, go to DONE. On watchdog expiry, go to DONE with abort.
  - DONE: a single cycle, then IDLE.
- **Arbitration:**
  - A `last` pointer holds the index of the last-served requester; it resets to 1, so `req0` wins first.
  - With one request, that requester wins.
  - With both requests, the requester that is not `last` wins, and `last` updates to the winner.
- **Load:**
  - On the IDLE→RUN transition, register the winner's `cmd/addr/wdata` into `commands/address/data_out`.
  - Set `enable=1` and pulse `gnt` for the winner.
  - The outputs hold stable for the whole of RUN.
- **Edge detect:**
  - `sclk` is registered once internally (`sclk_d`); an edge is `sclk & ~sclk_d`.
  - `sclk_d` is updated in every state.
  - Edge counter width is `$clog2(FRAME_BITS+1)`; it clears on load.
- **Watchdog:**
  - Counter width is `$clog2(TIMEOUT+1)`.
  - It clears on load and on every edge, and otherwise increments in RUN.
  - When it reaches `TIMEOUT`, the frame aborts.
- **Frame end (normal):**
  - On the RUN→DONE transition, `enable=0` and `done` pulses for the owner.
  - `commands/address/data_out` keep their last values until the next load.
- **Abort:** same as a normal end, and `err` also pulses in the same cycle as `done`.
- **Withdrawal:** dropping `req` before `gnt` withdraws the request with no side effect. `req` is ignored outside IDLE.
- **Reset:**
  - All outputs go to 0, state to IDLE, `last`=1, and all counters to 0.
  - Reset during RUN drops `enable` on the next edge with no `done`, `gnt` or `err` pulse.

## Timing
- `req` high in IDLE at cycle N → `gnt` and `enable`=1 with valid data in cycle N+1.
- The edge that completes `FRAME_BITS` is seen on `sclk` at cycle M; it is detected via `sclk_d`, and `enable`=0 and `done` follow in cycle M+1.
- DONE lasts exactly 1 cycle, so `enable` is low for at least 2 cycles between frames.
- The earliest next `gnt` is 2 cycles after `done`.
- An abort fires `TIMEOUT` cycles after the last edge, or after load if no edge occurred.
- `busy` is high from N+1 through the DONE cycle.

## Test plan
- **Single request:**
  - Stimulus: `req0` with `cmd0`=0x69, `addr0`=0x2AAAAC, `wdata0`=0x96AAE959; a `sclk` model toggles every 2 cycles.
  - Response: `gnt0` one cycle later and outputs match the inputs; after 64 edges, `done0` pulses, `enable`=0, `err`=0.
- **Simultaneous requests after reset:**
  - Stimulus: `req0` and `req1` high together and held.
  - Response: grant order is 0,1,0,1 over four frames.
  - Response: `commands` alternates between `cmd0` and `cmd1`.
  - Response: at least 2 `enable`-low cycles separate frames.
- **Watchdog:**
  - Stimulus: `TIMEOUT`=20; `sclk` stops after 10 edges.
  - Response: `err` and `done` pulse exactly 20 cycles after the 10th edge; `enable`=0.
- **Reset mid-frame:**
  - Stimulus: `rst` asserted after 30 edges.
  - Response: next cycle all outputs are 0 and there is no `done`.
  - Response: after release, a `req1`-only request is granted; a pending `req0` wins first because `last`=1.
- **Late request:** `req1` asserted during `req0`'s RUN → no `gnt1` until IDLE, and `cmd/address/data_out` stay unchanged during RUN.
- **Withdrawal:** `req0` pulsed high and low while the arbiter is in DONE → no `gnt0` and the arbiter stays in IDLE.

Source files
------------

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master between two requesters.
// Each grant runs exactly one frame, which ends when FRAME_BITS SCLK rises have been counted or the watchdog expires.
module spi_req_arbiter #(
  parameter int FRAME_BITS = 64,
  parameter int TIMEOUT    = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [7:0]  i_cmd0,
  input  logic [7:0]  i_cmd1,
  input  logic [23:0] i_addr0,
  input  logic [23:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic        i_sclk,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_done0,
  output logic        o_done1,
  output logic        o_enable,
  output logic [7:0]  o_commands,
  output logic [23:0] o_address,
  output logic [31:0] o_data_out,
  output logic        o_busy,
  output logic        o_err
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_last;
  logic            r_owner;
  logic            r_sclk_d;
  logic [CW-1:0]   r_cnt;
  logic [WW-1:0]   r_wd;

  logic            w_edge;
  logic            w_win;
  logic            w_last_edge;
  logic            w_expire;

  // Edge detect, winner selection and frame-end conditions
  always_comb begin
    w_edge = i_sclk & ~r_sclk_d;
    if (i_req0 && i_req1) begin
      w_win = ~r_last;
    end else if (i_req0) begin
      w_win = 1'b0;
    end else begin
      w_win = 1'b1;
    end
    w_last_edge = w_edge && (r_cnt == CW'(FRAME_BITS - 1));
    // An edge in the same cycle resets the watchdog, so it takes priority
    w_expire    = !w_edge && (r_wd == WW'(TIMEOUT - 1));
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_sclk_d   <= 1'b0;
      r_cnt      <= '0;
      r_wd       <= '0;
      o_gnt0     <= 1'b0;
      o_gnt1     <= 1'b0;
      o_done0    <= 1'b0;
      o_done1    <= 1'b0;
      o_enable   <= 1'b0;
      o_commands <= 8'h00;
      o_address  <= 24'h000000;
      o_data_out <= 32'h00000000;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      r_sclk_d <= i_sclk;
      o_gnt0   <= 1'b0;
      o_gnt1   <= 1'b0;
      o_done0  <= 1'b0;
      o_done1  <= 1'b0;
      o_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req0 || i_req1) begin
            r_last     <= w_win;
            r_owner    <= w_win;
            o_gnt0     <= ~w_win;
            o_gnt1     <= w_win;
            o_commands <= w_win ? i_cmd1   : i_cmd0;
            o_address  <= w_win ? i_addr1  : i_addr0;
            o_data_out <= w_win ? i_wdata1 : i_wdata0;
            o_enable   <= 1'b1;
            o_busy     <= 1'b1;
            r_cnt      <= '0;
            r_wd       <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_last_edge || w_expire) begin
            o_enable <= 1'b0;
            o_done0  <= ~r_owner;
            o_done1  <= r_owner;
            o_err    <= w_expire;
            r_cnt    <= w_edge ? (r_cnt + CW'(1)) : r_cnt;
            r_wd     <= '0;
            r_state  <= S_DONE;
          end else if (w_edge) begin
            r_cnt <= r_cnt + CW'(1);
            r_wd  <= '0;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_enable <= 1'b0;
          o_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: directed stimulus pushes expected grants/ends,
// and a negedge monitor pops and checks them against a behavioural SCLK source.
module tb_spi_req_arbiter;

  localparam int FRAME = 64;
  localparam int TMO   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, sclk = 1'b0;
  logic [7:0]  cmd0 = 8'h00, cmd1 = 8'h00;
  logic [23:0] addr0 = 24'h0, addr1 = 24'h0;
  logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;

  logic        o_gnt0, o_gnt1, o_done0, o_done1, o_enable, o_busy, o_err;
  logic [7:0]  o_commands;
  logic [23:0] o_address;
  logic [31:0] o_data_out;

  spi_req_arbiter #(.FRAME_BITS(FRAME), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1),
    .i_cmd0(cmd0), .i_cmd1(cmd1), .i_addr0(addr0), .i_addr1(addr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .i_sclk(sclk),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_done0(o_done0), .o_done1(o_done1),
    .o_enable(o_enable), .o_commands(o_commands), .o_address(o_address),
    .o_data_out(o_data_out), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    bit          idx;
    bit          err;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_gnt(input bit idx, input logic [7:0] c, input logic [23:0] a,
                          input logic [31:0] w, input int ec);
    exp_t e;
    e.is_done = 1'b0; e.idx = idx; e.err = 1'b0;
    e.cmd = c; e.addr = a; e.wdata = w; e.cyc = ec;
    q.push_back(e);
  endtask

  task automatic push_done(input bit idx, input bit err);
    exp_t e;
    e.is_done = 1'b1; e.idx = idx; e.err = err;
    e.cmd = 8'h00; e.addr = 24'h0; e.wdata = 32'h0; e.cyc = -1;
    q.push_back(e);
  endtask

  // which: 0 gnt0, 1 gnt1, 2 done0, 3 done1; returns on the negedge where it is seen
  task automatic wait_for(input int which, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = o_gnt0;
        1: seen = o_gnt1;
        2: seen = o_done0;
        3: seen = o_done1;
        default: seen = 1'b1;
      endcase
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_event_%0d: got no pulse expected pulse within %0d cycles", which, budget);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {o_gnt0, o_gnt1, o_done0, o_done1, o_enable, o_busy, o_err}, 64'h0);
    chk({tag, "_commands"}, o_commands, 64'h0);
    chk({tag, "_address"}, o_address, 64'h0);
    chk({tag, "_data_out"}, o_data_out, 64'h0);
  endtask

  // SCLK source: toggles every 2 cycles while enabled, stops rising after sclk_limit rises
  int sclk_limit = FRAME;
  int rises = 0;
  int last_rise = 0;
  int ph = 0;
  initial forever begin
    @(negedge clk);
    if (o_gnt0 || o_gnt1) begin
      rises = 0; ph = 0; sclk = 1'b0;
    end else if (o_enable) begin
      ph++;
      if (ph == 2) begin
        ph = 0;
        if (sclk) sclk = 1'b0;
        else if (rises < sclk_limit) begin
          sclk = 1'b1; rises++; last_rise = cyc;
        end
      end
    end else begin
      sclk = 1'b0; ph = 0;
    end
  end

  // Monitor: pops one expectation per grant/end pulse
  exp_t        m;
  logic [7:0]  lc = 8'h0;
  logic [23:0] la = 24'h0;
  logic [31:0] lw = 32'h0;
  bit          stable_ok = 1'b1;
  bit          prev_busy = 1'b0;
  int          gnt_cyc = 0;
  int          low_run = 100;
  initial forever begin
    @(negedge clk);
    if (o_gnt0 || o_gnt1 || o_done0 || o_done1) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {o_done1, o_done0, o_gnt1, o_gnt0}, 64'h0);
      end else begin
        m = q.pop_front();
        chk("pulse_kind", {o_done1, o_done0, o_gnt1, o_gnt0},
            m.is_done ? (m.idx ? 64'h8 : 64'h4) : (m.idx ? 64'h2 : 64'h1));
        if (!m.is_done) begin
          chk("gnt_commands", o_commands, m.cmd);
          chk("gnt_address", o_address, m.addr);
          chk("gnt_data_out", o_data_out, m.wdata);
          chk("gnt_enable", o_enable, 64'h1);
          chk("gnt_from_idle", prev_busy, 64'h0);
          chk("enable_low_gap_ge2", low_run >= 2, 64'h1);
          if (m.cyc >= 0) chk("gnt_latency", cyc, m.cyc);
          lc = o_commands; la = o_address; lw = o_data_out;
          stable_ok = 1'b1;
          gnt_cyc = cyc;
        end else begin
          chk("done_err", o_err, m.err);
          chk("done_enable_low", o_enable, 64'h0);
          chk("done_busy", o_busy, 64'h1);
          chk("run_outputs_stable", stable_ok, 64'h1);
          chk("done_outputs_held", {o_commands, o_address, o_data_out}, {lc, la, lw});
          // A rise driven in cycle c is detected on the edge ending c, so the counters restart in c+1
          if (m.err) chk("abort_cycle", cyc, (rises == 0 ? gnt_cyc : last_rise + 1) + TMO);
          else begin
            chk("edges_in_frame", rises, FRAME);
            chk("done_cycle", cyc, last_rise + 1);
          end
        end
      end
    end else begin
      if (o_err) chk("err_without_done", o_err, 64'h0);
      if (o_enable && ({o_commands, o_address, o_data_out} !== {lc, la, lw})) stable_ok = 1'b0;
    end
    prev_busy = o_busy;
    low_run = o_enable ? 0 : low_run + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by %0d cycles", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Single request
    @(negedge clk);
    cmd0 = 8'h69; addr0 = 24'h2AAAAC; wdata0 = 32'h96AAE959;
    push_gnt(1'b0, 8'h69, 24'h2AAAAC, 32'h96AAE959, cyc + 1);
    push_done(1'b0, 1'b0);
    req0 = 1'b1;
    wait_for(0, 10); req0 = 1'b0;
    wait_for(2, 400);
    repeat (3) @(negedge clk);

    // Simultaneous held requests after reset: order 0,1,0,1
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    cmd0 = 8'hA1; addr0 = 24'h123456; wdata0 = 32'hDEADBEEF;
    cmd1 = 8'h5E; addr1 = 24'hABCDEF; wdata1 = 32'h01234567;
    for (int k = 0; k < 2; k++) begin
      push_gnt(1'b0, 8'hA1, 24'h123456, 32'hDEADBEEF, -1); push_done(1'b0, 1'b0);
      push_gnt(1'b1, 8'h5E, 24'hABCDEF, 32'h01234567, -1); push_done(1'b1, 1'b0);
    end
    req0 = 1'b1; req1 = 1'b1;
    wait_for(0, 10); wait_for(1, 600); wait_for(0, 600); wait_for(1, 600);
    req0 = 1'b0; req1 = 1'b0;
    wait_for(3, 400);
    repeat (3) @(negedge clk);

    // Late request during RUN, with requester inputs changing under a live frame
    cmd0 = 8'h3C; addr0 = 24'h000001; wdata0 = 32'hFFFF0000;
    push_gnt(1'b0, 8'h3C, 24'h000001, 32'hFFFF0000, -1); push_done(1'b0, 1'b0);
    req0 = 1'b1;
    wait_for(0, 10); req0 = 1'b0;
    repeat (20) @(negedge clk);
    cmd0 = 8'hFF; addr0 = 24'hFFFFFF; wdata0 = 32'h00000000;
    cmd1 = 8'hC3; addr1 = 24'h800000; wdata1 = 32'h0000FFFF;
    push_gnt(1'b1, 8'hC3, 24'h800000, 32'h0000FFFF, -1); push_done(1'b1, 1'b0);
    req1 = 1'b1;
    wait_for(2, 400);
    wait_for(1, 10); req1 = 1'b0;
    wait_for(3, 400);
    repeat (3) @(negedge clk);

    // Watchdog: SCLK stalls after 10 edges
    sclk_limit = 10;
    cmd0 = 8'h05; addr0 = 24'h00AA55; wdata0 = 32'h12345678;
    push_gnt(1'b0, 8'h05, 24'h00AA55, 32'h12345678, -1); push_done(1'b0, 1'b1);
    req0 = 1'b1;
    wait_for(0, 10); req0 = 1'b0;
    wait_for(2, 200);
    sclk_limit = FRAME;
    repeat (3) @(negedge clk);

    // Reset mid-frame after 30 edges
    cmd0 = 8'h9F; addr0 = 24'h0F0F0F; wdata0 = 32'hCAFEF00D;
    push_gnt(1'b0, 8'h9F, 24'h0F0F0F, 32'hCAFEF00D, -1);
    req0 = 1'b1;
    wait_for(0, 10); req0 = 1'b0;
    for (int i = 0; i < 300 && rises < 30; i++) @(negedge clk);
    chk("reached_30_edges", rises >= 30, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midframe_reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Both pending after reset: req0 first even though req0 was served last before reset
    cmd0 = 8'h11; addr0 = 24'h111111; wdata0 = 32'h11111111;
    cmd1 = 8'h22; addr1 = 24'h222222; wdata1 = 32'h22222222;
    push_gnt(1'b0, 8'h11, 24'h111111, 32'h11111111, -1); push_done(1'b0, 1'b0);
    push_gnt(1'b1, 8'h22, 24'h222222, 32'h22222222, -1); push_done(1'b1, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    wait_for(0, 10); req0 = 1'b0;
    wait_for(1, 600); req1 = 1'b0;
    wait_for(3, 400);
    repeat (3) @(negedge clk);

    // req1-only request, then a req0 pulse confined to the DONE cycle
    cmd1 = 8'h77; addr1 = 24'h777777; wdata1 = 32'h77777777;
    push_gnt(1'b1, 8'h77, 24'h777777, 32'h77777777, -1); push_done(1'b1, 1'b0);
    req1 = 1'b1;
    wait_for(1, 10); req1 = 1'b0;
    wait_for(3, 400);
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("withdraw_busy", o_busy, 64'h0);
    chk("withdraw_enable", o_enable, 64'h0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
